// File: rtl/junction_lights_ctrl.sv
// Two-road UK junction light sequencer with pedestrian walk phase and fault-flash mode.
// Lamp outputs are registered copies of the decoded next state, so they track the state register.
module junction_lights_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_RED_AMBER = 2,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_AMBER     = 3,
  parameter int unsigned T_WALK      = 8,
  parameter int unsigned T_FLASH     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ped_req,
  input  logic flash_en,
  output logic a_red,
  output logic a_amber,
  output logic a_green,
  output logic b_red,
  output logic b_amber,
  output logic b_green,
  output logic walk,
  output logic ped_wait
);

  typedef enum logic [3:0] {
    StAllRedA,
    StARa,
    StAG,
    StAAm,
    StAllRedB,
    StBRa,
    StBG,
    StBAm,
    StPedWalk,
    StFlash
  } state_e;

  localparam logic [CNT_W-1:0] LimAllRed   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LimRedAmber = CNT_W'(T_RED_AMBER - 1);
  localparam logic [CNT_W-1:0] LimGreen    = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LimAmber    = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] LimWalk     = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] LimFlash    = CNT_W'(T_FLASH - 1);

  // Lamp bit order: {a_red, a_amber, a_green, b_red, b_amber, b_green, walk}
  localparam logic [6:0] LampsReset = 7'b100_100_0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic             road_q, road_d;  // road served after a walk: 0 = A, 1 = B
  logic             phase_q, phase_d;
  logic             ped_wait_q, ped_wait_d;
  logic [6:0]       lamps_q, lamps_d;
  logic             expire;

  function automatic logic [6:0] decode(state_e s, logic ph);
    logic [6:0] l;
    l = LampsReset;
    unique case (s)
      StARa:     l = 7'b110_100_0;
      StAG:      l = 7'b001_100_0;
      StAAm:     l = 7'b010_100_0;
      StBRa:     l = 7'b100_110_0;
      StBG:      l = 7'b100_001_0;
      StBAm:     l = 7'b100_010_0;
      StPedWalk: l = 7'b100_100_1;
      StFlash:   l = {1'b0, ph, 1'b0, 1'b0, ph, 1'b0, 1'b0};
      default:   l = LampsReset;
    endcase
    return l;
  endfunction

  always_comb begin
    lim = LimAllRed;
    unique case (state_q)
      StARa, StBRa: lim = LimRedAmber;
      StAG, StBG:   lim = LimGreen;
      StAAm, StBAm: lim = LimAmber;
      StPedWalk:    lim = LimWalk;
      StFlash:      lim = LimFlash;
      default:      lim = LimAllRed;
    endcase
  end

  assign expire = (cnt_q == lim);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    road_d     = road_q;
    phase_d    = phase_q;
    ped_wait_d = ped_wait_q | ped_req;

    if (flash_en) begin
      ped_wait_d = 1'b0;
      if (state_q != StFlash) begin
        state_d = StFlash;
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (expire) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end
    end else if (state_q == StFlash) begin
      state_d    = StAllRedA;
      cnt_d      = '0;
      road_d     = 1'b0;
      phase_d    = 1'b0;
      ped_wait_d = 1'b0;
    end else if (expire) begin
      cnt_d = '0;
      unique case (state_q)
        StAllRedA: begin
          if (ped_wait_q) begin
            state_d    = StPedWalk;
            road_d     = 1'b0;
            ped_wait_d = ped_req;  // a press on the clearing edge stays latched
          end else begin
            state_d = StARa;
          end
        end
        StARa:     state_d = StAG;
        StAG:      state_d = StAAm;
        StAAm:     state_d = StAllRedB;
        StAllRedB: begin
          if (ped_wait_q) begin
            state_d    = StPedWalk;
            road_d     = 1'b1;
            ped_wait_d = ped_req;
          end else begin
            state_d = StBRa;
          end
        end
        StBRa:     state_d = StBG;
        StBG:      state_d = StBAm;
        StBAm:     state_d = StAllRedA;
        // Skip the all-red so a held button cannot starve traffic.
        StPedWalk: state_d = road_q ? StBRa : StARa;
        default:   state_d = StAllRedA;
      endcase
    end

    lamps_d = decode(state_d, phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAllRedA;
      cnt_q      <= '0;
      road_q     <= 1'b0;
      phase_q    <= 1'b0;
      ped_wait_q <= 1'b0;
      lamps_q    <= LampsReset;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      road_q     <= road_d;
      phase_q    <= phase_d;
      ped_wait_q <= ped_wait_d;
      lamps_q    <= lamps_d;
    end
  end

  assign {a_red, a_amber, a_green, b_red, b_amber, b_green, walk} = lamps_q;
  assign ped_wait = ped_wait_q;

endmodule

// File: tb/tb_junction_lights_ctrl.sv
// Directed bench for junction_lights_ctrl: default timing instance plus an all-T=1 instance
// used for single-cycle phase checks and randomized safety checks.
module tb_junction_lights_ctrl;

  localparam logic [6:0] AllRed  = 7'b100_100_0;
  localparam logic [6:0] ARa     = 7'b110_100_0;
  localparam logic [6:0] AG      = 7'b001_100_0;
  localparam logic [6:0] AAm     = 7'b010_100_0;
  localparam logic [6:0] BRa     = 7'b100_110_0;
  localparam logic [6:0] BG      = 7'b100_001_0;
  localparam logic [6:0] BAm     = 7'b100_010_0;
  localparam logic [6:0] Walk    = 7'b100_100_1;
  localparam logic [6:0] FlashOn = 7'b010_010_0;
  localparam logic [6:0] FlashOf = 7'b000_000_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req = 1'b0, flash_en = 1'b0;
  logic ped1 = 1'b0, flash1 = 1'b0;
  logic ar, aa, ag, br, ba, bg, wk, pw;
  logic ar1, aa1, ag1, br1, ba1, bg1, wk1, pw1;
  logic [6:0] lamps, lamps1;
  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  always #5 clk = ~clk;

  assign lamps  = {ar, aa, ag, br, ba, bg, wk};
  assign lamps1 = {ar1, aa1, ag1, br1, ba1, bg1, wk1};

  junction_lights_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .flash_en(flash_en),
    .a_red(ar), .a_amber(aa), .a_green(ag), .b_red(br), .b_amber(ba), .b_green(bg),
    .walk(wk), .ped_wait(pw)
  );

  junction_lights_ctrl #(
    .CNT_W(16), .T_ALL_RED(1), .T_RED_AMBER(1), .T_GREEN(1), .T_AMBER(1), .T_WALK(1),
    .T_FLASH(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ped_req(ped1), .flash_en(flash1),
    .a_red(ar1), .a_amber(aa1), .a_green(ag1), .b_red(br1), .b_amber(ba1), .b_green(bg1),
    .walk(wk1), .ped_wait(pw1)
  );

  function automatic logic [6:0] norm_exp(int t);
    if (t == 0) return AllRed;
    if (t <= 2) return ARa;
    if (t <= 12) return AG;
    if (t <= 15) return AAm;
    if (t == 16) return AllRed;
    if (t <= 18) return BRa;
    if (t <= 28) return BG;
    return BAm;
  endfunction

  // Walk after ALL_RED_B, then road B, then back to ALL_RED_A and A_RA.
  function automatic logic [6:0] ped_exp(int t);
    if (t <= 16) return norm_exp(t);
    if (t <= 24) return Walk;
    if (t <= 26) return BRa;
    if (t <= 36) return BG;
    if (t <= 39) return BAm;
    if (t == 40) return AllRed;
    return ARa;
  endfunction

  // Button held: walk after every all-red once the first press is latched.
  function automatic logic [6:0] held_exp(int t);
    if (t <= 40) return ped_exp(t);
    if (t <= 48) return Walk;
    if (t <= 50) return ARa;
    return AG;
  endfunction

  function automatic logic [6:0] flash_exp(int t);
    if ((t >= 6 && t <= 9) || (t >= 14 && t <= 17)) return FlashOn;
    if (t <= 21) return FlashOf;
    if (t == 22) return AllRed;
    if (t <= 24) return ARa;
    return AG;
  endfunction

  function automatic logic [6:0] t1_exp(int t);
    logic [6:0] seq [8];
    seq = '{AllRed, ARa, AG, AAm, AllRed, BRa, BG, BAm};
    return seq[t % 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ped_req = 1'b0;
    flash_en = 1'b0;
    ped1 = 1'b0;
    flash1 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lamps !== AllRed || pw !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold lamps=%b ped_wait=%b want %b/0", lamps, pw, AllRed);
    end
    n_cmp++;
    if (lamps1 !== AllRed || pw1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold_t1 lamps=%b ped_wait=%b want %b/0", lamps1, pw1, AllRed);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    n_cmp++;
    if (lamps !== AllRed) begin
      n_err++;
      $display("FAIL reset_release lamps=%b want %b", lamps, AllRed);
    end
  endtask

  task automatic test_normal();
    do_reset();
    while (k < 64) begin
      n_cmp++;
      if (lamps !== norm_exp(k % 32) || pw !== 1'b0) begin
        n_err++;
        $display("FAIL normal k=%0d lamps=%b ped_wait=%b want %b/0", k, lamps, pw,
                 norm_exp(k % 32));
      end
      tick();
    end
  endtask

  task automatic test_ped_pulse();
    do_reset();
    while (k < 5) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    while (k <= 41) begin
      n_cmp++;
      if (lamps !== ped_exp(k) || pw !== (k <= 16)) begin
        n_err++;
        $display("FAIL ped_pulse k=%0d lamps=%b ped_wait=%b want %b/%0d", k, lamps, pw,
                 ped_exp(k), (k <= 16));
      end
      tick();
    end
  endtask

  task automatic test_ped_held();
    do_reset();
    ped_req = 1'b1;
    tick();
    while (k <= 60) begin
      n_cmp++;
      if (lamps !== held_exp(k) || pw !== 1'b1) begin
        n_err++;
        $display("FAIL ped_held k=%0d lamps=%b ped_wait=%b want %b/1", k, lamps, pw,
                 held_exp(k));
      end
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_flash();
    do_reset();
    while (k < 5) tick();
    flash_en = 1'b1;
    tick();
    while (k <= 25) begin
      n_cmp++;
      if (lamps !== flash_exp(k) || pw !== 1'b0) begin
        n_err++;
        $display("FAIL flash k=%0d lamps=%b ped_wait=%b want %b/0", k, lamps, pw,
                 flash_exp(k));
      end
      if (k == 8) ped_req = 1'b1;
      if (k == 20) ped_req = 1'b0;
      if (k == 21) flash_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (k < 20) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    n_cmp++;
    if (lamps !== BG || pw !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset lamps=%b ped_wait=%b want %b/1", lamps, pw, BG);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lamps !== AllRed || pw !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset lamps=%b ped_wait=%b want %b/0", lamps, pw, AllRed);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    while (k < 20) begin
      n_cmp++;
      if (lamps !== norm_exp(k)) begin
        n_err++;
        $display("FAIL restart k=%0d lamps=%b want %b", k, lamps, norm_exp(k));
      end
      tick();
    end
  endtask

  task automatic test_t1_seq();
    do_reset();
    while (k < 16) begin
      n_cmp++;
      if (lamps1 !== t1_exp(k)) begin
        n_err++;
        $display("FAIL t1_seq k=%0d lamps=%b want %b", k, lamps1, t1_exp(k));
      end
      tick();
    end
  endtask

  task automatic test_random_safety();
    logic bad;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      ped1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) flash1 = ~flash1;
      tick();
      bad = (ag1 && bg1) || ((ag1 || bg1) && wk1) || (ag1 && ar1) || (bg1 && br1) ||
            (wk1 && !(ar1 && br1)) || (wk1 && pw1 && 1'b0);
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL safety cycle=%0d lamps=%b want no conflict", i, lamps1);
      end
    end
    flash1 = 1'b0;
    ped1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ped_pulse();
    test_ped_held();
    test_flash();
    test_reset_mid();
    test_t1_seq();
    test_random_safety();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
